// File: rtl/asrv32_clint.sv
// asrv32_clint: machine timer (mtime/mtimecmp) and software interrupt (msip)
// responder on the core data bus; keeps the core's CSR timer copies coherent.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_addr, i_wr_data       bus byte address and lane-aligned store data
//   i_wr_mask, i_wr_en      byte-lane write mask and write enable
//   o_rd_data               registered read data (address of previous cycle)
//   o_software_interrupt    msip[0]
//   o_timer_irq             registered unsigned compare mtime >= mtimecmp
//   o_mtime_wr              one-cycle strobe after a bus write to mtime
//   o_mtimecmp_wr           one-cycle strobe after a bus write to mtimecmp
//   o_mtime_din             live mtime value
//   o_mtimecmp_din          live mtimecmp value
module asrv32_clint #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int unsigned CLK_FREQ_MHZ = 100
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wr_data,
    input  logic [3:0]  i_wr_mask,
    input  logic        i_wr_en,
    output logic [31:0] o_rd_data,
    output logic        o_software_interrupt,
    output logic        o_timer_irq,
    output logic        o_mtime_wr,
    output logic        o_mtimecmp_wr,
    output logic [63:0] o_mtime_din,
    output logic [63:0] o_mtimecmp_din
);

    localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_FREQ_MHZ - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic [63:0]   mtime;
    logic [63:0]   mtime_nxt;
    logic [63:0]   mtimecmp;
    logic [63:0]   mtimecmp_nxt;
    logic          msip;
    logic          sel;
    logic          we;
    logic [2:0]    off;
    logic          wr_msip;
    logic          wr_cmp_lo;
    logic          wr_cmp_hi;
    logic          wr_mt_lo;
    logic          wr_mt_hi;
    logic [31:0]   rd_nxt;
    logic          unused_addr;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] din,
        input logic [3:0]  m
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                r[8*i +: 8] = din[8*i +: 8];
            end
        end
        return r;
    endfunction

    assign sel         = (i_addr[31:5] == BASE_ADDR[31:5]);
    assign we          = i_wr_en && sel;
    assign off         = i_addr[4:2];
    assign unused_addr = ^i_addr[1:0];

    assign wr_msip   = we && (off == 3'd0);
    assign wr_cmp_lo = we && (off == 3'd2);
    assign wr_cmp_hi = we && (off == 3'd3);
    assign wr_mt_lo  = we && (off == 3'd4);
    assign wr_mt_hi  = we && (off == 3'd5);

    assign tick = (presc == PMAX);

    always_comb begin
        mtimecmp_nxt = mtimecmp;
        if (wr_cmp_lo) begin
            mtimecmp_nxt[31:0] = merge(mtimecmp[31:0], i_wr_data, i_wr_mask);
        end
        if (wr_cmp_hi) begin
            mtimecmp_nxt[63:32] = merge(mtimecmp[63:32], i_wr_data, i_wr_mask);
        end
    end

    // A bus write to either half swallows a coincident tick.
    always_comb begin
        mtime_nxt = mtime;
        if (wr_mt_lo) begin
            mtime_nxt[31:0] = merge(mtime[31:0], i_wr_data, i_wr_mask);
        end else if (wr_mt_hi) begin
            mtime_nxt[63:32] = merge(mtime[63:32], i_wr_data, i_wr_mask);
        end else if (tick) begin
            mtime_nxt = mtime + 64'd1;
        end
    end

    always_comb begin
        rd_nxt = 32'd0;
        if (sel) begin
            case (off)
                3'd0:    rd_nxt = {31'd0, msip};
                3'd2:    rd_nxt = mtimecmp[31:0];
                3'd3:    rd_nxt = mtimecmp[63:32];
                3'd4:    rd_nxt = mtime[31:0];
                3'd5:    rd_nxt = mtime[63:32];
                default: rd_nxt = 32'd0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc         <= '0;
            mtime         <= 64'd0;
            mtimecmp      <= '1;
            msip          <= 1'b0;
            o_rd_data     <= 32'd0;
            o_mtime_wr    <= 1'b0;
            o_mtimecmp_wr <= 1'b0;
            o_timer_irq   <= 1'b0;
        end else begin
            presc         <= tick ? '0 : presc + 1'b1;
            mtime         <= mtime_nxt;
            mtimecmp      <= mtimecmp_nxt;
            if (wr_msip && i_wr_mask[0]) begin
                msip <= i_wr_data[0];
            end
            o_rd_data     <= rd_nxt;
            o_mtime_wr    <= wr_mt_lo || wr_mt_hi;
            o_mtimecmp_wr <= wr_cmp_lo || wr_cmp_hi;
            o_timer_irq   <= (mtime >= mtimecmp);
        end
    end

    assign o_software_interrupt = msip;
    assign o_mtime_din          = mtime;
    assign o_mtimecmp_din       = mtimecmp;

endmodule

// File: tb/tb_asrv32_clint.sv
// tb_asrv32_clint: self-checking bench for asrv32_clint.
// Reads go through a queue of expected values popped when data returns.
module tb_asrv32_clint;

    localparam int          P    = 4;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_wr_data = 32'd0;
    logic [3:0]  i_wr_mask = 4'd0;
    logic        i_wr_en = 1'b0;
    logic [31:0] o_rd_data;
    logic        o_software_interrupt;
    logic        o_timer_irq;
    logic        o_mtime_wr;
    logic        o_mtimecmp_wr;
    logic [63:0] o_mtime_din;
    logic [63:0] o_mtimecmp_din;

    int n_chk = 0;
    int n_err = 0;
    int edges;

    logic [63:0] mt_base;
    int          w_edge;
    logic [63:0] cmp_m;
    logic        msip_m;
    logic [31:0] exp_q[$];

    asrv32_clint #(
        .BASE_ADDR(BASE),
        .CLK_FREQ_MHZ(P)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_addr(i_addr),
        .i_wr_data(i_wr_data),
        .i_wr_mask(i_wr_mask),
        .i_wr_en(i_wr_en),
        .o_rd_data(o_rd_data),
        .o_software_interrupt(o_software_interrupt),
        .o_timer_irq(o_timer_irq),
        .o_mtime_wr(o_mtime_wr),
        .o_mtimecmp_wr(o_mtimecmp_wr),
        .o_mtime_din(o_mtime_din),
        .o_mtimecmp_din(o_mtimecmp_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] old,
                                           input logic [31:0] d,
                                           input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // mtime after edge k: ticks fall on edges that are multiples of P.
    function automatic logic [63:0] mt_at(input int k);
        return mt_base + 64'(k / P) - 64'(w_edge / P);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        logic [63:0] t;
        t = mt_at(edges);
        if (a[31:5] != BASE[31:5]) return 32'd0;
        case (a[4:2])
            3'd0:    return {31'd0, msip_m};
            3'd2:    return cmp_m[31:0];
            3'd3:    return cmp_m[63:32];
            3'd4:    return t[31:0];
            3'd5:    return t[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        mt_base = 64'd0;
        w_edge  = 0;
        cmp_m   = '1;
        msip_m  = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_rd"}, 64'(o_rd_data), 64'd0);
        check({tag, "_mwr"}, 64'(o_mtime_wr), 64'd0);
        check({tag, "_cwr"}, 64'(o_mtimecmp_wr), 64'd0);
        check({tag, "_irq"}, 64'(o_timer_irq), 64'd0);
        check({tag, "_sw"}, 64'(o_software_interrupt), 64'd0);
        check({tag, "_mt"}, o_mtime_din, 64'd0);
        check({tag, "_cmp"}, o_mtimecmp_din, 64'hFFFF_FFFF_FFFF_FFFF);
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic rd(input string tag, input logic [31:0] a);
        i_addr  = a;
        i_wr_en = 1'b0;
        exp_q.push_back(exp_rd(a));
        @(posedge clk);
        #1;
        check(tag, 64'(o_rd_data), 64'(exp_q.pop_front()));
        @(negedge clk);
    endtask

    task automatic wr(input string tag, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] m);
        logic [63:0] cur;
        logic        mw;
        logic        cw;
        mw  = 1'b0;
        cw  = 1'b0;
        cur = mt_at(edges);
        if (a[31:5] == BASE[31:5]) begin
            case (a[4:2])
                3'd0: if (m[0]) msip_m = d[0];
                3'd2: begin
                    cmp_m[31:0] = bmerge(cmp_m[31:0], d, m);
                    cw = 1'b1;
                end
                3'd3: begin
                    cmp_m[63:32] = bmerge(cmp_m[63:32], d, m);
                    cw = 1'b1;
                end
                3'd4: begin
                    mt_base = {cur[63:32], bmerge(cur[31:0], d, m)};
                    w_edge  = edges + 1;
                    mw = 1'b1;
                end
                3'd5: begin
                    mt_base = {bmerge(cur[63:32], d, m), cur[31:0]};
                    w_edge  = edges + 1;
                    mw = 1'b1;
                end
                default: ;
            endcase
        end
        i_addr    = a;
        i_wr_data = d;
        i_wr_mask = m;
        i_wr_en   = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_mwr"}, 64'(o_mtime_wr), 64'(mw));
        check({tag, "_cwr"}, 64'(o_mtimecmp_wr), 64'(cw));
        check({tag, "_mt"}, o_mtime_din, mt_at(edges));
        check({tag, "_cmp"}, o_mtimecmp_din, cmp_m);
        check({tag, "_sw"}, 64'(o_software_interrupt), 64'(msip_m));
        @(negedge clk);
        i_wr_en = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_mwr0"}, 64'(o_mtime_wr), 64'd0);
        check({tag, "_cwr0"}, 64'(o_mtimecmp_wr), 64'd0);
        @(negedge clk);
    endtask

    task automatic align(input int r);
        while ((edges + 1) % P != r) @(negedge clk);
    endtask

    initial begin
        logic seen;
        logic e_irq;
        model_reset();
        #12;
        chk_reset("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running count from reset
        repeat (40) @(negedge clk);
        check("idle_mwr", 64'(o_mtime_wr), 64'd0);
        check("idle_cwr", 64'(o_mtimecmp_wr), 64'd0);
        check("idle_irq", 64'(o_timer_irq), 64'd0);
        check("idle_mt", mt_at(edges), 64'd10);
        rd("rd_mt_lo", BASE + 32'h10);
        rd("rd_mt_hi", BASE + 32'h14);

        // Compare match and interrupt rise
        wr("cmp_lo", BASE + 32'h08, 32'h0000_0020, 4'hF);
        wr("cmp_hi", BASE + 32'h0C, 32'h0000_0000, 4'hF);
        check("cmp_val", o_mtimecmp_din, 64'h20);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk);
            #1;
            e_irq = (mt_at(edges - 1) >= cmp_m);
            check("irq", 64'(o_timer_irq), 64'(e_irq));
            seen = e_irq;
            @(negedge clk);
        end
        check("irq_seen", 64'(seen), 64'd1);

        // Low-half overflow carries into the high half
        align(1);
        wr("mt_lo", BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
        wr("mt_hi", BASE + 32'h14, 32'h0000_0000, 4'hF);
        repeat (2) @(negedge clk);
        rd("carry_hi", BASE + 32'h14);
        rd("carry_lo", BASE + 32'h10);
        check("carry_mt", o_mtime_din, mt_at(edges));

        // msip, holes and out-of-window accesses
        wr("msip1", BASE, 32'h0000_0001, 4'hF);
        rd("rd_msip1", BASE);
        wr("msip0", BASE, 32'hFFFF_FFFE, 4'hF);
        rd("rd_msip0", BASE);
        wr("hole", BASE + 32'h04, 32'hFFFF_FFFF, 4'hF);
        rd("rd_hole", BASE + 32'h04);
        wr("outside", BASE + 32'h28, 32'h1234_5678, 4'hF);
        rd("rd_outside", BASE + 32'h28);
        rd("rd_cmp_lo", BASE + 32'h08);

        // Write landing on a tick edge, then reset mid-operation
        wr("msip_set", BASE, 32'h0000_0001, 4'hF);
        align(0);
        wr("mt_tick", BASE + 32'h10, 32'h0000_1234, 4'hF);
        rd("rd_mt_tick", BASE + 32'h10);
        i_addr    = BASE + 32'h10;
        i_wr_data = 32'h5;
        i_wr_mask = 4'hF;
        i_wr_en   = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_mwr", 64'(o_mtime_wr), 64'd1);
        check("pre_rst_irq", 64'(o_timer_irq), 64'd1);
        check("pre_rst_sw", 64'(o_software_interrupt), 64'd1);
        #1;
        rst_n   = 1'b0;
        i_wr_en = 1'b0;
        #1;
        chk_reset("rst1");
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;

        // Single byte lane on reset mtimecmp
        wr("cmp_byte", BASE + 32'h08, 32'hAB00_CD00, 4'b0010);
        check("cmp_byte_val", o_mtimecmp_din, 64'hFFFF_FFFF_FFFF_CDFF);
        rd("rd_cmp_byte_lo", BASE + 32'h08);
        rd("rd_cmp_byte_hi", BASE + 32'h0C);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
